axi4_lite_reg_bridge: RTL and testbench

AXI4-Lite slave front end that converts AXI4-Lite write and read transactions into the single-cycle req/ack register bus consumed by the register interface blocks: wreq/waddr/wdata/wack/werr and rreq/raddr/rdata/rack/rerr. The write and read paths are independent, with one outstanding transaction per direction. A timeout counter guarantees completion when no register block claims the address.

---
 rtl/axi4_lite_reg_bridge.sv | 235 +++++++++++++++++++++++
 tb/tb_axi4_lite_reg_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_reg_bridge.sv
// AXI4-Lite slave front end driving a single-cycle req/ack register bus.
// Write and read paths are independent FSMs, one outstanding transaction each.
// A per-path timeout completes unclaimed accesses with DECERR.
`timescale 1ns/1ps
module axi4_lite_reg_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  axi_clk,
    input  logic                  axi_rstn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  axi_wreq,
    output logic [13:0]           axi_waddr,
    output logic [31:0]           axi_wdata,
    input  logic                  axi_wack,
    input  logic                  axi_werr,
    output logic                  axi_rreq,
    output logic [13:0]           axi_raddr,
    input  logic [31:0]           axi_rdata,
    input  logic                  axi_rack,
    input  logic                  axi_rerr
);

    // Counter only needs to reach TIMEOUT_CYCLES-1: the timeout fires on the
    // last unacknowledged wait cycle instead of counting one more.
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_t;

    w_state_t         w_state_reg;
    r_state_t         r_state_reg;
    logic             aw_done_reg;
    logic             w_done_reg;
    logic             wstrb_ok_reg;
    logic [CNT_W-1:0] w_cnt_reg;
    logic [CNT_W-1:0] r_cnt_reg;

    logic             awready_reg;
    logic             wready_reg;
    logic [1:0]       bresp_reg;
    logic             bvalid_reg;
    logic             arready_reg;
    logic [31:0]      rdata_reg;
    logic [1:0]       rresp_reg;
    logic             rvalid_reg;
    logic             wreq_reg;
    logic [13:0]      waddr_reg;
    logic [31:0]      wdata_reg;
    logic             rreq_reg;
    logic [13:0]      raddr_reg;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic wstrb_ok_now;
    logic unused_addr_bits;

    assign aw_hs        = s_axi_awvalid && awready_reg;
    assign w_hs         = s_axi_wvalid && wready_reg;
    assign ar_hs        = s_axi_arvalid && arready_reg;
    // Strobe decision uses the live strobe if W lands in the completing cycle.
    assign wstrb_ok_now = w_hs ? (s_axi_wstrb == 4'hF) : wstrb_ok_reg;
    // Byte-lane and upper address bits are deliberately ignored.
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    assign s_axi_awready = awready_reg;
    assign s_axi_wready  = wready_reg;
    assign s_axi_bresp   = bresp_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_arready = arready_reg;
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = rresp_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign axi_wreq      = wreq_reg;
    assign axi_waddr     = waddr_reg;
    assign axi_wdata     = wdata_reg;
    assign axi_rreq      = rreq_reg;
    assign axi_raddr     = raddr_reg;

    // Write FSM: collect AW and W in any order, issue one wreq, await wack or timeout.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            w_state_reg  <= W_IDLE;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            wstrb_ok_reg <= 1'b0;
            w_cnt_reg    <= '0;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            bresp_reg    <= 2'b00;
            bvalid_reg   <= 1'b0;
            wreq_reg     <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs) begin
                        waddr_reg   <= s_axi_awaddr[15:2];
                        awready_reg <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end else if (!aw_done_reg) begin
                        awready_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_reg    <= s_axi_wdata;
                        wstrb_ok_reg <= (s_axi_wstrb == 4'hF);
                        wready_reg   <= 1'b0;
                        w_done_reg   <= 1'b1;
                    end else if (!w_done_reg) begin
                        wready_reg <= 1'b1;
                    end
                    if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        if (wstrb_ok_now) begin
                            wreq_reg    <= 1'b1;
                            w_state_reg <= W_REQ;
                        end else begin
                            // Partial writes are refused without touching the register bus.
                            bresp_reg   <= RESP_SLVERR;
                            bvalid_reg  <= 1'b1;
                            w_state_reg <= W_RESP;
                        end
                    end
                end
                W_REQ: begin
                    wreq_reg    <= 1'b0;
                    w_cnt_reg   <= '0;
                    w_state_reg <= W_WAIT;
                end
                W_WAIT: begin
                    if (axi_wack) begin
                        bresp_reg   <= axi_werr ? RESP_SLVERR : RESP_OKAY;
                        bvalid_reg  <= 1'b1;
                        w_state_reg <= W_RESP;
                    end else if (w_cnt_reg == CNT_LAST) begin
                        bresp_reg   <= RESP_DECERR;
                        bvalid_reg  <= 1'b1;
                        w_state_reg <= W_RESP;
                    end else begin
                        w_cnt_reg <= w_cnt_reg + 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // Read FSM: accept AR, issue one rreq, await rack or timeout, hold R until taken.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_state_reg <= R_IDLE;
            r_cnt_reg   <= '0;
            arready_reg <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= 2'b00;
            rvalid_reg  <= 1'b0;
            rreq_reg    <= 1'b0;
            raddr_reg   <= '0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_hs) begin
                        raddr_reg   <= s_axi_araddr[15:2];
                        arready_reg <= 1'b0;
                        rreq_reg    <= 1'b1;
                        r_state_reg <= R_REQ;
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                R_REQ: begin
                    rreq_reg    <= 1'b0;
                    r_cnt_reg   <= '0;
                    r_state_reg <= R_WAIT;
                end
                R_WAIT: begin
                    if (axi_rack) begin
                        rdata_reg   <= axi_rdata;
                        rresp_reg   <= axi_rerr ? RESP_SLVERR : RESP_OKAY;
                        rvalid_reg  <= 1'b1;
                        r_state_reg <= R_RESP;
                    end else if (r_cnt_reg == CNT_LAST) begin
                        rdata_reg   <= '0;
                        rresp_reg   <= RESP_DECERR;
                        rvalid_reg  <= 1'b1;
                        r_state_reg <= R_RESP;
                    end else begin
                        r_cnt_reg <= r_cnt_reg + 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        rvalid_reg  <= 1'b0;
                        arready_reg <= 1'b1;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_bridge.sv
// Directed bench for axi4_lite_reg_bridge: a vector table driven through an
// AXI master task plus hand-written sequences for timing and reset corners.
`timescale 1ns/1ps
module tb_axi4_lite_reg_bridge;

    logic        axi_clk = 1'b0;
    logic        axi_rstn = 1'b0;
    logic [15:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [15:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        axi_wreq;
    logic [13:0] axi_waddr;
    logic [31:0] axi_wdata;
    logic        axi_wack = 1'b0;
    logic        axi_werr = 1'b0;
    logic        axi_rreq;
    logic [13:0] axi_raddr;
    logic [31:0] axi_rdata = '0;
    logic        axi_rack = 1'b0;
    logic        axi_rerr = 1'b0;

    axi4_lite_reg_bridge #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
        .axi_clk(axi_clk), .axi_rstn(axi_rstn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .axi_wreq(axi_wreq), .axi_waddr(axi_waddr), .axi_wdata(axi_wdata),
        .axi_wack(axi_wack), .axi_werr(axi_werr),
        .axi_rreq(axi_rreq), .axi_raddr(axi_raddr), .axi_rdata(axi_rdata),
        .axi_rack(axi_rack), .axi_rerr(axi_rerr)
    );

    always #5 axi_clk = ~axi_clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Responder configuration: mode 0 = ack OK, 1 = ack with error, 2 = silent.
    int          w_mode = 0;
    int          r_mode = 0;
    logic [31:0] r_value = '0;
    int          w_inj_req = 0;
    int          w_inj_done = 0;
    int          wreq_count = 0;
    int          rreq_count = 0;
    logic [13:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [13:0] last_raddr = '0;
    bit          w_fire = 1'b0;
    bit          r_fire = 1'b0;

    typedef struct {
        bit          is_rd;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;
        logic [13:0] exp_addr;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_reqs;
    } vec_t;

    vec_t vecs[8];

    // Register-block model: acks one cycle after the req pulse (fastest legal ack).
    initial begin : responder
        forever begin
            @(negedge axi_clk);
            axi_wack  = 1'b0;
            axi_werr  = 1'b0;
            axi_rack  = 1'b0;
            axi_rerr  = 1'b0;
            axi_rdata = 32'h5A5A_5A5A;
            if (w_fire) begin
                axi_wack = 1'b1;
                axi_werr = (w_mode == 1);
                w_fire   = 1'b0;
            end
            if (w_inj_done != w_inj_req) begin
                axi_wack   = 1'b1;
                w_inj_done = w_inj_req;
            end
            if (axi_wreq) begin
                wreq_count++;
                last_waddr = axi_waddr;
                last_wdata = axi_wdata;
                w_fire     = (w_mode != 2);
            end
            if (r_fire) begin
                axi_rack  = 1'b1;
                axi_rerr  = (r_mode == 1);
                axi_rdata = r_value;
                r_fire    = 1'b0;
            end
            if (axi_rreq) begin
                rreq_count++;
                last_raddr = axi_raddr;
                r_fire     = (r_mode != 2);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Full AXI transaction with BREADY/RREADY held high; starts and ends on a negedge.
    task automatic do_txn(input vec_t v, output logic [1:0] resp, output logic [31:0] rd);
        int guard;
        bit a_done;
        bit d_done;
        bit a_hs;
        bit d_hs;
        resp = 2'bxx;
        rd   = 32'h0;
        if (!v.is_rd) begin
            w_mode = v.mode;
            s_axi_awaddr = v.addr; s_axi_wdata = v.data; s_axi_wstrb = v.strb;
            s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
            a_done = 1'b0; d_done = 1'b0; guard = 0;
            while (!(a_done && d_done) && guard < 20) begin
                a_hs = s_axi_awvalid && s_axi_awready;
                d_hs = s_axi_wvalid && s_axi_wready;
                @(negedge axi_clk);
                if (a_hs) begin s_axi_awvalid = 1'b0; a_done = 1'b1; end
                if (d_hs) begin s_axi_wvalid = 1'b0; d_done = 1'b1; end
                guard++;
            end
            chk("aw_w_accept", {a_done, d_done}, 2'b11);
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
            guard = 0;
            while (!s_axi_bvalid && guard < 40) begin @(negedge axi_clk); guard++; end
            chk("bvalid_seen", s_axi_bvalid, 1'b1);
            resp = s_axi_bresp;
            @(negedge axi_clk);
            chk("bvalid_drop", s_axi_bvalid, 1'b0);
            s_axi_bready = 1'b0;
        end else begin
            r_mode = v.mode; r_value = v.data;
            s_axi_araddr = v.addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
            a_done = 1'b0; guard = 0;
            while (!a_done && guard < 20) begin
                a_hs = s_axi_arready;
                @(negedge axi_clk);
                if (a_hs) begin s_axi_arvalid = 1'b0; a_done = 1'b1; end
                guard++;
            end
            chk("ar_accept", a_done, 1'b1);
            s_axi_arvalid = 1'b0;
            guard = 0;
            while (!s_axi_rvalid && guard < 40) begin @(negedge axi_clk); guard++; end
            chk("rvalid_seen", s_axi_rvalid, 1'b1);
            resp = s_axi_rresp;
            rd   = s_axi_rdata;
            @(negedge axi_clk);
            chk("rvalid_drop", s_axi_rvalid, 1'b0);
            s_axi_rready = 1'b0;
        end
    endtask

    initial begin : main
        logic [1:0]  resp;
        logic [1:0]  resp2;
        logic [31:0] rd;
        logic [31:0] rd2;
        int          reqs_before;
        int          cnt;
        vec_t        wv;
        vec_t        rv;

        //          rd   addr      data          strb  mode exp_addr  resp   rdata         reqs
        vecs[0] = '{1'b0, 16'h2004, 32'hDEADBEEF, 4'hF, 0, 14'h0801, 2'b00, 32'h0,        1};
        vecs[1] = '{1'b1, 16'h2004, 32'hDEADBEEF, 4'hF, 0, 14'h0801, 2'b00, 32'hDEADBEEF, 1};
        vecs[2] = '{1'b0, 16'h2020, 32'h12345678, 4'hF, 1, 14'h0808, 2'b10, 32'h0,        1};
        vecs[3] = '{1'b1, 16'h0000, 32'h0,        4'hF, 2, 14'h0000, 2'b11, 32'h0,        1};
        vecs[4] = '{1'b0, 16'h0010, 32'h11112222, 4'h3, 0, 14'h0004, 2'b10, 32'h0,        0};
        vecs[5] = '{1'b1, 16'h3FFC, 32'h0000A5A5, 4'hF, 1, 14'h0FFF, 2'b10, 32'h0000A5A5, 1};
        vecs[6] = '{1'b0, 16'hFFFF, 32'h87654321, 4'hF, 2, 14'h3FFF, 2'b11, 32'h0,        1};
        vecs[7] = '{1'b1, 16'h1003, 32'h0BADF00D, 4'hF, 0, 14'h0400, 2'b00, 32'h0BADF00D, 1};

        // Reset state
        repeat (3) @(negedge axi_clk);
        chk("reset_ctrl", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                           s_axi_rvalid, s_axi_rresp, axi_wreq, axi_rreq}, '0);
        chk("reset_data", {s_axi_rdata, axi_wdata}, '0);
        chk("reset_addr", {axi_waddr, axi_raddr}, '0);
        axi_rstn = 1'b1;
        @(negedge axi_clk);
        chk("ready_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // Same-cycle AW+W, exact latency, then B back-pressure
        w_mode = 0;
        reqs_before = wreq_count;
        s_axi_awaddr = 16'h2004; s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge axi_clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("lat_wreq_t1", axi_wreq, 1'b1);
        chk("lat_waddr", axi_waddr, 14'h0801);
        chk("lat_wdata", axi_wdata, 32'hDEADBEEF);
        chk("lat_readies_low", {s_axi_awready, s_axi_wready}, 2'b00);
        @(negedge axi_clk);
        chk("lat_wreq_pulse_end", axi_wreq, 1'b0);
        chk("lat_bvalid_t2", s_axi_bvalid, 1'b0);
        @(negedge axi_clk);
        chk("lat_bvalid_t3", s_axi_bvalid, 1'b1);
        chk("lat_bresp", s_axi_bresp, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge axi_clk);
            chk("bp_hold", {s_axi_bvalid, s_axi_bresp, s_axi_awready}, 4'b1000);
        end
        s_axi_bready = 1'b1;
        @(negedge axi_clk);
        s_axi_bready = 1'b0;
        chk("bp_release", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b011);
        chk("lat_wreq_count", wreq_count - reqs_before, 1);
        $display("txn seq_latency write 2004 bresp=%b", 2'b00);

        // W two cycles ahead of AW
        s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge axi_clk);
        s_axi_wvalid = 1'b0;
        chk("wfirst_wready_drop", {s_axi_wready, s_axi_awready}, 2'b01);
        @(negedge axi_clk);
        chk("wfirst_no_req_a", axi_wreq, 1'b0);
        @(negedge axi_clk);
        chk("wfirst_no_req_b", axi_wreq, 1'b0);
        s_axi_awaddr = 16'h2008; s_axi_awvalid = 1'b1; s_axi_bready = 1'b1;
        @(negedge axi_clk);
        s_axi_awvalid = 1'b0;
        chk("wfirst_wreq", axi_wreq, 1'b1);
        chk("wfirst_waddr", axi_waddr, 14'h0802);
        chk("wfirst_wdata", axi_wdata, 32'hCAFEF00D);
        cnt = 0;
        while (!s_axi_bvalid && cnt < 40) begin @(negedge axi_clk); cnt++; end
        chk("wfirst_bresp", {s_axi_bvalid, s_axi_bresp}, 3'b100);
        @(negedge axi_clk);
        s_axi_bready = 1'b0;
        $display("txn seq_wfirst write 2008 bresp=%b", 2'b00);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            reqs_before = vecs[i].is_rd ? rreq_count : wreq_count;
            do_txn(vecs[i], resp, rd);
            chk($sformatf("vec%0d_resp", i), resp, vecs[i].exp_resp);
            if (vecs[i].is_rd) begin
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
                chk($sformatf("vec%0d_reqs", i), rreq_count - reqs_before, vecs[i].exp_reqs);
                chk($sformatf("vec%0d_raddr", i), last_raddr, vecs[i].exp_addr);
            end else begin
                chk($sformatf("vec%0d_reqs", i), wreq_count - reqs_before, vecs[i].exp_reqs);
                if (vecs[i].exp_reqs != 0) begin
                    chk($sformatf("vec%0d_waddr", i), last_waddr, vecs[i].exp_addr);
                    chk($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].data);
                end
            end
            $display("txn vec%0d %s addr=%h resp=%b rdata=%h", i, vecs[i].is_rd ? "read " : "write",
                     vecs[i].addr, resp, rd);
        end

        // Read timeout: RVALID exactly 16 cycles after entering the wait state
        r_mode = 2;
        s_axi_araddr = 16'h0000; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        @(negedge axi_clk);
        s_axi_arvalid = 1'b0;
        chk("to_rreq", {axi_rreq, axi_raddr}, {1'b1, 14'h0000});
        cnt = 0;
        while (!s_axi_rvalid && cnt < 40) begin @(negedge axi_clk); cnt++; end
        chk("to_latency", cnt, 17);
        chk("to_rresp", s_axi_rresp, 2'b11);
        chk("to_rdata", s_axi_rdata, 32'h0);
        @(negedge axi_clk);
        s_axi_rready = 1'b0;
        $display("txn seq_timeout read 0000 cycles=%0d", cnt);

        // Concurrent write and read
        wv = '{1'b0, 16'h0100, 32'h00C0FFEE, 4'hF, 1, 14'h0040, 2'b10, 32'h0, 1};
        rv = '{1'b1, 16'h0204, 32'h13579BDF, 4'hF, 0, 14'h0081, 2'b00, 32'h13579BDF, 1};
        fork
            do_txn(wv, resp, rd);
            do_txn(rv, resp2, rd2);
        join
        chk("conc_bresp", resp, 2'b10);
        chk("conc_rresp", resp2, 2'b00);
        chk("conc_rdata", rd2, 32'h13579BDF);
        chk("conc_addrs", {last_waddr, last_raddr}, {14'h0040, 14'h0081});
        $display("txn seq_concurrent bresp=%b rresp=%b rdata=%h", resp, resp2, rd2);

        // Reset during W_WAIT, late ack ignored, then a clean write
        w_mode = 2;
        s_axi_awaddr = 16'h2030; s_axi_wdata = 32'hFEEDFACE; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        @(negedge axi_clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("rst_wreq", axi_wreq, 1'b1);
        repeat (2) @(negedge axi_clk);
        axi_rstn = 1'b0;
        #1;
        chk("rst_mid_ctrl", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                             s_axi_rvalid, s_axi_rresp, axi_wreq, axi_rreq}, '0);
        chk("rst_mid_data", {s_axi_rdata, axi_wdata}, '0);
        chk("rst_mid_addr", {axi_waddr, axi_raddr}, '0);
        @(negedge axi_clk);
        axi_rstn = 1'b1;
        w_inj_req++;
        reqs_before = wreq_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge axi_clk);
            chk("rst_late_ack_ignored", {s_axi_bvalid, axi_wreq}, 2'b00);
        end
        chk("rst_readies_back", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        chk("rst_no_new_req", wreq_count - reqs_before, 0);
        s_axi_bready = 1'b0;
        wv = '{1'b0, 16'h2040, 32'h0F0F0F0F, 4'hF, 0, 14'h0810, 2'b00, 32'h0, 1};
        do_txn(wv, resp, rd);
        chk("post_rst_bresp", resp, 2'b00);
        chk("post_rst_waddr", {last_waddr, last_wdata}, {14'h0810, 32'h0F0F0F0F});
        $display("txn seq_reset write 2040 bresp=%b", resp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
